// File: rtl/game_phase_pkg.sv
// Shared constants for the game phase sequencer: phase encodings,
// keypad bit positions and the welcome-menu choice code.
package game_phase_pkg;

    // Phase encodings, also consumed by the display mux
    localparam logic [2:0] PH_WELCOME   = 3'd0;
    localparam logic [2:0] PH_PLAYING   = 3'd1;
    localparam logic [2:0] PH_PAUSED    = 3'd2;
    localparam logic [2:0] PH_DYING     = 3'd3;
    localparam logic [2:0] PH_GAME_OVER = 3'd4;
    localparam logic [2:0] PH_WIN       = 3'd5;

    // Keypad movement-bus bit positions
    localparam int KEY_CONFIRM = 4;
    localparam int KEY_PAUSE   = 5;

    // Welcome controller state meaning "two-player selected"
    localparam logic [1:0] WEL_CHOICE_2P = 2'b01;

    // Phases that dwell for a fixed hold time
    function automatic logic is_hold_phase(input logic [2:0] ph);
        return (ph == PH_DYING) || (ph == PH_GAME_OVER) || (ph == PH_WIN);
    endfunction

endpackage

// File: rtl/key_rise_detect.sv
// Per-bit rising-edge detector: a held key produces exactly one rise.
module key_rise_detect #(
    parameter int N = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N-1:0] i_d,
    output logic [N-1:0] o_rise
);

    logic [N-1:0] r_prev;

    // Remember last cycle's key levels; reset clears the history
    always_ff @(posedge i_clk) begin
        if (i_rst) r_prev <= '0;
        else       r_prev <= i_d;
    end

    assign o_rise = i_d & ~r_prev;

endmodule

// File: rtl/game_phase_ctrl.sv
// Top-level game sequencer: owns the game phase, hands off to the welcome
// controller, gates the gameplay datapath and tracks remaining lives.
module game_phase_ctrl
    import game_phase_pkg::*;
#(
    parameter int INIT_LIVES  = 3,
    parameter int LIFE_W      = 2,
    parameter int HOLD_CYCLES = 50000000,
    parameter int TIMER_W     = 26
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [5:0]        i_movement,
    input  logic              i_welcome_end,
    input  logic [1:0]        i_welcome_choice,
    input  logic              i_player_dead,
    input  logic              i_level_clear,
    output logic              o_welcome_start,
    output logic              o_game_enable,
    output logic              o_respawn,
    output logic              o_two_player,
    output logic [LIFE_W-1:0] o_lives,
    output logic [2:0]        o_phase
);

    logic [2:0]         r_phase;
    logic [LIFE_W-1:0]  r_lives;
    logic [TIMER_W-1:0] r_timer;
    logic               r_two_player;
    logic               r_welcome_start;
    logic               r_game_enable;
    logic               r_respawn;

    logic [1:0]         w_keys;
    logic [1:0]         w_rise;
    logic               w_confirm_rise;
    logic               w_pause_rise;
    logic               w_expire;
    logic [2:0]         w_next_phase;
    logic [LIFE_W-1:0]  w_next_lives;
    logic               w_next_two_player;
    logic               w_unused;

    // Only confirm and pause matter here; the direction bits belong to game logic
    assign w_unused = ^i_movement[3:0];

    assign w_keys = {i_movement[KEY_PAUSE], i_movement[KEY_CONFIRM]};

    key_rise_detect #(.N(2)) u_keys (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_d    (w_keys),
        .o_rise (w_rise)
    );

    assign w_confirm_rise = w_rise[0];
    assign w_pause_rise   = w_rise[1];
    assign w_expire       = (r_timer == TIMER_W'(HOLD_CYCLES - 1));

    // Next phase, lives and mode from the current phase and input events
    always_comb begin
        w_next_phase      = r_phase;
        w_next_lives      = r_lives;
        w_next_two_player = r_two_player;
        case (r_phase)
            PH_WELCOME: begin
                // welcome_end is only trusted once the welcome block has been started
                if (r_welcome_start && i_welcome_end) begin
                    w_next_two_player = (i_welcome_choice == WEL_CHOICE_2P);
                    w_next_lives      = LIFE_W'(INIT_LIVES);
                    w_next_phase      = PH_PLAYING;
                end
            end
            PH_PLAYING: begin
                if (i_level_clear) begin
                    w_next_phase = PH_WIN;
                end else if (i_player_dead) begin
                    if (r_lives > LIFE_W'(1)) begin
                        w_next_lives = r_lives - LIFE_W'(1);
                        w_next_phase = PH_DYING;
                    end else begin
                        w_next_lives = '0;
                        w_next_phase = PH_GAME_OVER;
                    end
                end else if (w_pause_rise) begin
                    w_next_phase = PH_PAUSED;
                end
            end
            PH_PAUSED: begin
                if (w_pause_rise) w_next_phase = PH_PLAYING;
            end
            PH_DYING: begin
                if (w_expire) w_next_phase = PH_PLAYING;
            end
            PH_GAME_OVER, PH_WIN: begin
                if (w_expire || w_confirm_rise) w_next_phase = PH_WELCOME;
            end
            default: w_next_phase = PH_WELCOME;
        endcase
    end

    // State, lives and mode registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_phase      <= PH_WELCOME;
            r_lives      <= '0;
            r_two_player <= 1'b0;
        end else begin
            r_phase      <= w_next_phase;
            r_lives      <= w_next_lives;
            r_two_player <= w_next_two_player;
        end
    end

    // Hold timer: restarts on any phase change, counts while dwelling
    always_ff @(posedge i_clk) begin
        if (i_rst)                         r_timer <= '0;
        else if (w_next_phase != r_phase)  r_timer <= '0;
        else if (is_hold_phase(r_phase))   r_timer <= r_timer + TIMER_W'(1);
    end

    // Registered control outputs; welcome_start lags the phase by one cycle
    // so leaving WELCOME always gives the welcome block a low cycle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_welcome_start <= 1'b0;
            r_game_enable   <= 1'b0;
            r_respawn       <= 1'b0;
        end else begin
            r_welcome_start <= (r_phase == PH_WELCOME);
            r_game_enable   <= (w_next_phase == PH_PLAYING);
            r_respawn       <= (r_phase == PH_DYING) && (w_next_phase == PH_PLAYING);
        end
    end

    assign o_phase         = r_phase;
    assign o_lives         = r_lives;
    assign o_two_player    = r_two_player;
    assign o_welcome_start = r_welcome_start;
    assign o_game_enable   = r_game_enable;
    assign o_respawn       = r_respawn;

endmodule

// File: tb/tb_game_phase_ctrl.sv
// Bench for game_phase_ctrl: directed scenarios then random stimulus,
// every cycle compared against a behavioural model of the game rules.
module tb_game_phase_ctrl;

    localparam int HOLD  = 8;
    localparam int LIVES = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] movement;
    logic       welcome_end;
    logic [1:0] welcome_choice;
    logic       player_dead;
    logic       level_clear;
    logic       welcome_start, game_enable, respawn, two_player;
    logic [1:0] lives;
    logic [2:0] phase;

    int n_vec = 0;
    int n_bad = 0;

    // Model state (phases numbered as the display sees them)
    int m_phase, m_lives, m_2p, m_ws, m_resp, m_ge, m_dwell;
    int m_prev_conf, m_prev_pause;

    always #5 clk = ~clk;

    game_phase_ctrl #(
        .INIT_LIVES (LIVES),
        .LIFE_W     (2),
        .HOLD_CYCLES(HOLD),
        .TIMER_W    (4)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_movement      (movement),
        .i_welcome_end   (welcome_end),
        .i_welcome_choice(welcome_choice),
        .i_player_dead   (player_dead),
        .i_level_clear   (level_clear),
        .o_welcome_start (welcome_start),
        .o_game_enable   (game_enable),
        .o_respawn       (respawn),
        .o_two_player    (two_player),
        .o_lives         (lives),
        .o_phase         (phase)
    );

    task automatic chk(input string tag, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d want %0d", tag, $time, act, exp);
        end
    endtask

    // One clock of the game rules, from the inputs applied this cycle
    task automatic model_step();
        int old, nxt, cr, pr;
        if (rst) begin
            m_phase = 0; m_lives = 0; m_2p = 0; m_ws = 0; m_resp = 0; m_ge = 0;
            m_dwell = 1; m_prev_conf = 0; m_prev_pause = 0;
            return;
        end
        cr  = (movement[4] && !m_prev_conf) ? 1 : 0;
        pr  = (movement[5] && !m_prev_pause) ? 1 : 0;
        old = m_phase;
        nxt = old;
        m_resp = 0;
        if (old == 0) begin
            if (m_ws == 1 && welcome_end) begin
                m_2p = (welcome_choice == 2'b01) ? 1 : 0;
                m_lives = LIVES;
                nxt = 1;
            end
        end else if (old == 1) begin
            if (level_clear) nxt = 5;
            else if (player_dead) begin
                if (m_lives == 1) begin m_lives = 0; nxt = 4; end
                else begin m_lives = m_lives - 1; nxt = 3; end
            end else if (pr == 1) nxt = 2;
        end else if (old == 2) begin
            if (pr == 1) nxt = 1;
        end else if (old == 3) begin
            if (m_dwell == HOLD) begin nxt = 1; m_resp = 1; end
        end else begin
            if (m_dwell == HOLD || cr == 1) nxt = 0;
        end
        m_ws    = (old == 0) ? 1 : 0;
        m_ge    = (nxt == 1) ? 1 : 0;
        m_dwell = (nxt != old) ? 1 : m_dwell + 1;
        m_phase = nxt;
        m_prev_conf  = movement[4];
        m_prev_pause = movement[5];
    endtask

    task automatic cmp_all();
        chk("phase",         int'(phase),         m_phase);
        chk("lives",         int'(lives),         m_lives);
        chk("game_enable",   int'(game_enable),   m_ge);
        chk("respawn",       int'(respawn),       m_resp);
        chk("two_player",    int'(two_player),    m_2p);
        chk("welcome_start", int'(welcome_start), m_ws);
    endtask

    // Apply one cycle of inputs, advance the model, compare after the edge
    task automatic cyc(input logic r, input logic [5:0] mv, input logic we,
                       input logic [1:0] ch, input logic pd, input logic lc);
        rst = r; movement = mv; welcome_end = we; welcome_choice = ch;
        player_dead = pd; level_clear = lc;
        @(posedge clk);
        model_step();
        #1;
        cmp_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 6'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    endtask

    // From reset, wait for welcome_start and start a game with the given choice
    task automatic start_game(input logic [1:0] ch);
        cyc(1'b1, 6'd0, 1'b0, 2'd0, 1'b0, 1'b0);
        idle(2);
        cyc(1'b0, 6'd0, 1'b1, ch, 1'b0, 1'b0);
    endtask

    logic [5:0] rmv;

    initial begin
        // Reset state and a two-player start
        cyc(1'b1, 6'd0, 1'b0, 2'd0, 1'b0, 1'b0);
        chk("rst_phase", int'(phase), 0);
        chk("rst_ws",    int'(welcome_start), 0);
        cyc(1'b0, 6'd0, 1'b1, 2'b01, 1'b0, 1'b0);   // ws still low: ignored
        chk("end_ignored", int'(phase), 0);
        idle(1);
        cyc(1'b0, 6'd0, 1'b1, 2'b01, 1'b0, 1'b0);
        chk("start_phase", int'(phase), 1);
        chk("start_2p",    int'(two_player), 1);
        chk("start_lives", int'(lives), 3);
        idle(2);

        // Death with lives left, full dying hold, respawn pulse
        cyc(1'b0, 6'd0, 1'b0, 2'd0, 1'b1, 1'b0);
        chk("dying_phase", int'(phase), 3);
        chk("dying_lives", int'(lives), 2);
        idle(12);
        cyc(1'b0, 6'd0, 1'b0, 2'd0, 1'b1, 1'b0);
        idle(10);

        // Last life: game over, confirm held from the second cycle
        cyc(1'b0, 6'd0, 1'b0, 2'd0, 1'b1, 1'b0);
        chk("go_phase", int'(phase), 4);
        chk("go_lives", int'(lives), 0);
        idle(1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 6'b010000, 1'b0, 2'd0, 1'b0, 1'b0);
        idle(2);

        // Single-player game to game over without confirm
        start_game(2'b00);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 6'd0, 1'b0, 2'd0, 1'b1, 1'b0);
            idle(11);
        end

        // Pause held long, release, press again; death while paused ignored
        start_game(2'b01);
        for (int i = 0; i < 20; i++) cyc(1'b0, 6'b100000, 1'b0, 2'd0, 1'b0, 1'b0);
        chk("pause_held", int'(phase), 2);
        idle(1);
        cyc(1'b0, 6'b100000, 1'b0, 2'd0, 1'b0, 1'b0);
        chk("unpause", int'(phase), 1);
        idle(1);
        cyc(1'b0, 6'b100000, 1'b0, 2'd0, 1'b0, 1'b0);
        cyc(1'b0, 6'b100000, 1'b0, 2'd0, 1'b1, 1'b1);
        chk("paused_lives", int'(lives), 3);
        idle(1);
        cyc(1'b0, 6'b100000, 1'b0, 2'd0, 1'b0, 1'b0);

        // Death and level clear together: win, lives kept
        cyc(1'b0, 6'd0, 1'b0, 2'd0, 1'b1, 1'b1);
        chk("win_phase", int'(phase), 5);
        chk("win_lives", int'(lives), 3);
        idle(10);

        // Reset in the middle of the dying hold
        cyc(1'b0, 6'd0, 1'b1, 2'd0, 1'b0, 1'b0);
        cyc(1'b0, 6'd0, 1'b0, 2'd0, 1'b1, 1'b0);
        idle(3);
        cyc(1'b1, 6'd0, 1'b0, 2'd0, 1'b0, 1'b0);
        chk("midhold_rst_phase", int'(phase), 0);
        chk("midhold_rst_lives", int'(lives), 0);
        idle(1);
        chk("ws_after_rst", int'(welcome_start), 1);

        // Random play
        rmv = 6'd0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) rmv[4] = ~rmv[4];
            if ($urandom_range(0, 7) == 0) rmv[5] = ~rmv[5];
            rmv[3:0] = 4'($urandom);
            cyc(($urandom_range(0, 599) == 0),
                rmv,
                ($urandom_range(0, 3) == 0),
                2'($urandom),
                ($urandom_range(0, 11) == 0),
                ($urandom_range(0, 49) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
